uart2wb_cmd: RTL and testbench

UART2WB_CMD -- requirements
Module: uart2wb_cmd

---
 rtl/uart2wb_cmd.sv | 117 +++++++++++
 tb/tb_uart2wb_cmd.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart2wb_cmd.sv
// rtl/uart2wb_cmd.sv - UART byte stream to Wishbone command word decoder
// Frame: header {SYNC, cmd}, then four big-endian payload bytes unless cmd is a read.
module uart2wb_cmd #(
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [5:0]  SYNC        = 6'b101010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  input  logic        i_busy,
  output logic [33:0] o_WB_ctr_w,
  output logic        o_WB_o_cyc,
  output logic        o_err
);

  localparam int             TW    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]  T_LIM = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, OUT} state_t;

  state_t        state, state_nx;
  logic [1:0]    cmd, cmd_nx;
  logic [23:0]   payload, payload_nx;
  logic [1:0]    cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [33:0]   ctr_nx;
  logic          err_nx;
  logic          live;
  logic          xfer;

  // live keeps ready low during reset and for the first edge after release
  assign o_rx_ready = live && (state != OUT);
  assign xfer       = i_rx_valid && o_rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cmd        <= 2'd0;
      payload    <= 24'd0;
      cnt        <= 2'd0;
      tcnt       <= '0;
      o_WB_ctr_w <= 34'd0;
      o_err      <= 1'b0;
      live       <= 1'b0;
    end else begin
      state      <= state_nx;
      cmd        <= cmd_nx;
      payload    <= payload_nx;
      cnt        <= cnt_nx;
      tcnt       <= tcnt_nx;
      o_WB_ctr_w <= ctr_nx;
      o_err      <= err_nx;
      live       <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    cmd_nx     = cmd;
    payload_nx = payload;
    cnt_nx     = cnt;
    tcnt_nx    = tcnt;
    ctr_nx     = o_WB_ctr_w;
    err_nx     = 1'b0;
    o_WB_o_cyc = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (i_rx_data[7:2] == SYNC) begin
            cmd_nx     = i_rx_data[1:0];
            payload_nx = 24'd0;
            cnt_nx     = 2'd0;
            tcnt_nx    = '0;
            if (i_rx_data[1:0] == 2'd0) begin
              ctr_nx   = 34'd0;
              state_nx = OUT;
            end else begin
              state_nx = DATA;
            end
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          tcnt_nx    = '0;
          payload_nx = {payload[15:0], i_rx_data};
          cnt_nx     = 2'(cnt + 2'd1);
          // the last byte goes straight into the command word
          if (cnt == 2'd3) begin
            ctr_nx   = {cmd, payload, i_rx_data};
            cnt_nx   = 2'd0;
            state_nx = OUT;
          end
        end else if (tcnt == T_LIM) begin
          err_nx   = 1'b1;
          cnt_nx   = 2'd0;
          tcnt_nx  = '0;
          state_nx = IDLE;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      OUT: begin
        if (!i_busy) begin
          o_WB_o_cyc = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart2wb_cmd.sv
// tb/tb_uart2wb_cmd.sv - scoreboard bench for uart2wb_cmd with a frame-level reference model
module tb_uart2wb_cmd;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic        i_busy = 1'b0;
  logic        o_rx_ready;
  logic [33:0] o_WB_ctr_w;
  logic        o_WB_o_cyc;
  logic        o_err;

  uart2wb_cmd #(.TIMEOUT_CYC(TO), .SYNC(6'b101010)) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready), .i_busy(i_busy), .o_WB_ctr_w(o_WB_ctr_w),
    .o_WB_o_cyc(o_WB_o_cyc), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_err; logic [33:0] val;} ev_t;
  ev_t exp_q[$];
  int errs = 0;
  int checks = 0;

  bit          m_in_data = 1'b0;
  logic [1:0]  m_cmd = 2'd0;
  logic [31:0] m_pl = 32'd0;
  int          m_n = 0;
  bit          rand_busy = 1'b0;
  bit          busy_force = 1'b0;
  bit          prev_cyc = 1'b0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_err, input logic [33:0] val);
    ev_t e;
    e.is_err = is_err;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Frame-level model: g is the number of idle cycles before byte b
  task automatic model_byte(input logic [7:0] b, input int g);
    if (m_in_data && g >= TO) begin
      push_ev(1'b1, 34'd0);
      m_in_data = 1'b0;
    end
    if (!m_in_data) begin
      if (b[7:2] == 6'b101010) begin
        m_cmd = b[1:0];
        m_pl = 32'd0;
        m_n = 0;
        if (b[1:0] == 2'd0) push_ev(1'b0, 34'd0);
        else m_in_data = 1'b1;
      end else begin
        push_ev(1'b1, 34'd0);
      end
    end else begin
      m_pl = (m_pl << 8) | {24'd0, b};
      m_n++;
      if (m_n == 4) begin
        push_ev(1'b0, {m_cmd, m_pl});
        m_in_data = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int g);
    int   waits;
    logic rdy;
    bit   done;
    model_byte(b, g);
    repeat (g) begin
      i_rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    i_rx_valid = 1'b1;
    i_rx_data = b;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      rdy = o_rx_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
      else begin
        waits++;
        if (waits > 200) begin
          checks++;
          errs++;
          $display("FAIL accept_wait: byte %h never accepted", b);
          done = 1'b1;
        end
      end
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", 34'(exp_q.size()), 34'd0);
  endtask

  always @(posedge clk) begin
    #2;
    i_busy = rand_busy ? ($urandom_range(0, 2) == 0) : busy_force;
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      if (o_WB_o_cyc) begin
        chk("cyc_with_err", 34'(o_err), 34'd0);
        chk("cyc_back_to_back", 34'(prev_cyc), 34'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_cyc", 34'd1, 34'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cyc_kind", 34'(e.is_err), 34'd0);
          chk("ctr_w", o_WB_ctr_w, e.val);
        end
      end else if (o_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 34'd1, 34'd0);
        end else begin
          e = exp_q.pop_front();
          chk("err_kind", 34'(e.is_err), 34'd1);
        end
      end
      prev_cyc = o_WB_o_cyc;
    end else begin
      prev_cyc = 1'b0;
    end
  end

  initial begin
    int gaps[8];
    int g;
    logic [7:0] b;
    gaps = '{0, 0, 0, 1, 2, 7, 8, 12};

    #2;
    chk("rst_ready", 34'(o_rx_ready), 34'd0);
    chk("rst_ctr", o_WB_ctr_w, 34'd0);
    chk("rst_cyc", 34'(o_WB_o_cyc), 34'd0);
    chk("rst_err", 34'(o_err), 34'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst_ready_held", 34'(o_rx_ready), 34'd0);
    #2 rst = 1'b1;
    #1 chk("ready_before_edge", 34'(o_rx_ready), 34'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 34'(o_rx_ready), 34'd1);

    send_byte(8'hA9, 0); send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    drain();

    send_byte(8'hA8, 0);
    chk("read_latency_cyc", 34'(o_WB_o_cyc), 34'd1);
    chk("read_ready_low", 34'(o_rx_ready), 34'd0);
    chk("read_ctr", o_WB_ctr_w, 34'h0_00000000);
    drain();

    send_byte(8'h55, 0);
    send_byte(8'hA9, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    drain();

    send_byte(8'hAA, 0); send_byte(8'h11, 0);
    send_byte(8'hAB, 8); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h05, 0);
    drain();

    send_byte(8'hAA, 0); send_byte(8'h11, 0); send_byte(8'h22, 7);
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    drain();

    busy_force = 1'b1;
    @(posedge clk); #1;
    send_byte(8'hA9, 0); send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", 34'(o_rx_ready), 34'd0);
      chk("bp_ctr", o_WB_ctr_w, 34'h1_DEADBEEF);
      chk("bp_cyc", 34'(o_WB_o_cyc), 34'd0);
      @(posedge clk); #1;
    end
    busy_force = 1'b0;
    drain();

    send_byte(8'hA9, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_ctr", o_WB_ctr_w, 34'd0);
    chk("arst_ready", 34'(o_rx_ready), 34'd0);
    chk("arst_cyc", 34'(o_WB_o_cyc), 34'd0);
    chk("arst_err", 34'(o_err), 34'd0);
    m_in_data = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    send_byte(8'hA9, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    drain();

    rand_busy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 4) != 0) b = {6'b101010, 2'($urandom_range(0, 3))};
      else b = 8'($urandom);
      g = gaps[$urandom_range(0, 7)];
      send_byte(b, g);
    end
    rand_busy = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
